// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Optional feature macro: FETCH_PERF_EN (adds fetch/stall counters to fetch_unit).
package fetch_pkg;

  // Bytes per instruction; the PC advances by this much per issued fetch.
  localparam int INSTR_BYTES = 4;

  // Canonical no-op encoding (addi x0, x0, 0) for consumers that need a filler word.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Low PC bits that must be zero for an aligned instruction address.
  localparam logic [31:0] PC_LOW_BITS = 32'h0000_0003;

  // Default buffer entry: the PC a word was fetched from and the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Flush empties the buffer in one cycle; the head slot is always visible.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the ROM address every cycle,
// captures the registered ROM word one cycle later and buffers {pc, instr} for decode.
// Optional feature macro: FETCH_PERF_EN (perf_fetched / perf_stall counters).
//
// Handshake: decode takes the head entry on any cycle where out_valid and out_ready
// are both high; out_valid depends only on state, out_ready may change freely and
// out_pc/out_instr are meaningful only while out_valid is high.
import fetch_pkg::*;

module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] req_pc;
  logic                     req_pending;
  logic [CNT_W-1:0]         count;
  logic [OCC_W-1:0]         occupancy;
  logic                     deq;
  logic                     issue;
  logic                     push;
  entry_t                   push_data;
  entry_t                   head;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  assign deq = out_valid & out_ready;

  // Entries the buffer will hold once this cycle's response and pop settle; a new
  // request is only issued when its response is guaranteed a free slot.
  assign occupancy = OCC_W'(count) + OCC_W'(req_pending) - OCC_W'(deq);
  assign issue     = !redirect_valid && (occupancy < OCC_W'(FIFO_DEPTH));

  // A response from the previous cycle's request is dropped if a redirect lands now.
  assign push            = req_pending & !redirect_valid;
  assign push_data.pc    = req_pc;
  assign push_data.instr = imem_instr;

  // PC and outstanding-request tracking; a redirect kills the in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      req_pending <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_target & ~ADDRESS_WIDTH'(PC_LOW_BITS);
      req_pending <= 1'b0;
    end else if (issue) begin
      pc          <= pc + ADDRESS_WIDTH'(INSTR_BYTES);
      req_pc      <= pc;
      req_pending <= 1'b1;
    end else begin
      req_pending <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (deq),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

`ifdef FETCH_PERF_EN
  // Free-running wrap-around counters of buffered fetches and back-pressured cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset / wrap sequences.
module tb_fetch_unit;

  localparam int FIFO_DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT 0: default reset PC ----------------
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_fetched2;
  logic [31:0] perf_stall2;
`endif

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  // ---------------- DUT 1: reset PC near the top of the address space ----------------
  logic [31:0] imem_addr2;
  logic [31:0] imem_instr2 = '0;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_target2 = '0;
  logic        out_ready2 = 1'b1;

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'hFFFF_FFF8),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut2 (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr2),
    .imem_instr      (imem_instr2),
    .redirect_valid  (redirect_valid2),
    .redirect_target (redirect_target2),
    .out_valid       (out_valid2),
    .out_ready       (out_ready2),
    .out_pc          (out_pc2),
    .out_instr       (out_instr2)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched2),
    .perf_stall      (perf_stall2)
`endif
  );

  // Registered ROM models: word n lives at byte address 4n and holds value n.
  always @(posedge clk) begin
    imem_instr  <= imem_addr >> 2;
    imem_instr2 <= imem_addr2 >> 2;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // A push must never land in a full buffer.
  always @(negedge clk) begin
    if (reset === 1'b1 && dut.push === 1'b1) begin
      n_cmp++;
      if (int'(dut.u_fifo.count) >= FIFO_DEPTH) begin
        n_bad++;
        $display("FAIL push_full: count %0d depth %0d", dut.u_fifo.count, FIFO_DEPTH);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rdy, input logic rv, input logic [31:0] rt,
                         input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                         input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rt = rt;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: time %0t limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Columns: ready, redirect, target | exp valid, exp pc, exp instr, exp imem_addr
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h000); // c0 first request on the bus
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h004); // c1 response in flight
    add_vec(1, 0, 32'h0,   1, 32'h000, 32'h00, 32'h008); // c2 first valid on edge 2
    add_vec(1, 0, 32'h0,   1, 32'h004, 32'h01, 32'h00C);
    add_vec(0, 0, 32'h0,   1, 32'h008, 32'h02, 32'h010); // c4 stall starts
    add_vec(0, 0, 32'h0,   1, 32'h008, 32'h02, 32'h010); // buffer full, address frozen
    add_vec(0, 0, 32'h0,   1, 32'h008, 32'h02, 32'h010);
    add_vec(0, 0, 32'h0,   1, 32'h008, 32'h02, 32'h010);
    add_vec(0, 0, 32'h0,   1, 32'h008, 32'h02, 32'h010);
    add_vec(1, 0, 32'h0,   1, 32'h008, 32'h02, 32'h010); // c9 resume
    add_vec(1, 0, 32'h0,   1, 32'h00C, 32'h03, 32'h014);
    add_vec(1, 0, 32'h0,   1, 32'h010, 32'h04, 32'h018);
    add_vec(0, 1, 32'h100, 1, 32'h014, 32'h05, 32'h01C); // c12 redirect: entry buffered + request pending
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h100); // stale 0x18 dropped
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h104);
    add_vec(1, 0, 32'h0,   1, 32'h100, 32'h40, 32'h108);
    add_vec(1, 1, 32'h103, 1, 32'h104, 32'h41, 32'h10C); // c16 redirect with handshake, unaligned target
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h100);
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h104);
    add_vec(1, 1, 32'h200, 1, 32'h100, 32'h40, 32'h108); // c19 first of two back-to-back redirects
    add_vec(1, 1, 32'h300, 0, 32'h000, 32'h00, 32'h200); // c20 second one wins
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h300);
    add_vec(1, 0, 32'h0,   0, 32'h000, 32'h00, 32'h304);
    add_vec(1, 0, 32'h0,   1, 32'h300, 32'hC0, 32'h308);
    add_vec(1, 0, 32'h0,   1, 32'h304, 32'hC1, 32'h30C);

    // Reset state
    reset           = 1'b0;
    out_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    step();
    step();
    chk("rst_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_pc",    0, out_pc,         32'h0);
    chk("rst_instr", 0, out_instr,      32'h0);
    chk("rst_addr",  0, imem_addr,      32'h0);
    chk("rst_addr2", 0, imem_addr2,     32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", 0, perf_fetched, 32'h0);
    chk("rst_perf_stall",   0, perf_stall,   32'h0);
`endif
    reset = 1'b1;

    // Table-driven main run
    for (int i = 0; i < vecs.size(); i++) begin
      out_ready       = vecs[i].rdy;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      #1;
      chk("valid", i, 32'(out_valid), 32'(vecs[i].ev));
      chk("addr",  i, imem_addr,      vecs[i].eaddr);
      if (vecs[i].ev) begin
        chk("pc",    i, out_pc,    vecs[i].epc);
        chk("instr", i, out_instr, vecs[i].einstr);
      end
`ifdef FETCH_PERF_EN
      if (i == vecs.size() - 1) begin
        chk("perf_fetched", i, perf_fetched, 32'd11);
        chk("perf_stall",   i, perf_stall,   32'd6);
      end
`endif
      step();
    end
    redirect_valid  = 1'b0;
    redirect_target = '0;
    out_ready       = 1'b1;

    // Mid-stream asynchronous reset: head (0x308, 0xC2) is valid right now
    chk("pre_rst_valid", 0, 32'(out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 0, 32'(out_valid), 32'h0);
    chk("mid_rst_addr",  0, imem_addr,      32'h0);
    chk("mid_rst_pc",    0, out_pc,         32'h0);
    chk("mid_rst_addr2", 0, imem_addr2,     32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
    chk("mid_rst_perf_fetched", 0, perf_fetched, 32'h0);
    chk("mid_rst_perf_stall",   0, perf_stall,   32'h0);
`endif
    step();
    step();
    reset = 1'b1;

    // Restart from RESET_PC on both instances; dut2 wraps past the top of memory
    #1;
    chk("rs_valid",  0, 32'(out_valid),  32'h0);
    chk("rs_addr",   0, imem_addr,       32'h0);
    chk("wrap_addr", 0, imem_addr2,      32'hFFFF_FFF8);
    step();
    chk("rs_valid",  1, 32'(out_valid),  32'h0);
    chk("rs_addr",   1, imem_addr,       32'h4);
    chk("wrap_valid",1, 32'(out_valid2), 32'h0);
    chk("wrap_addr", 1, imem_addr2,      32'hFFFF_FFFC);
    step();
    chk("rs_valid",  2, 32'(out_valid),  32'h1);
    chk("rs_pc",     2, out_pc,          32'h0);
    chk("rs_instr",  2, out_instr,       32'h0);
    chk("wrap_valid",2, 32'(out_valid2), 32'h1);
    chk("wrap_pc",   2, out_pc2,         32'hFFFF_FFF8);
    chk("wrap_instr",2, out_instr2,      32'h3FFF_FFFE);
    chk("wrap_addr", 2, imem_addr2,      32'h0);
    step();
    chk("rs_pc",     3, out_pc,          32'h4);
    chk("rs_instr",  3, out_instr,       32'h1);
    chk("wrap_pc",   3, out_pc2,         32'hFFFF_FFFC);
    chk("wrap_instr",3, out_instr2,      32'h3FFF_FFFF);
    step();
    chk("rs_pc",     4, out_pc,          32'h8);
    chk("wrap_valid",4, 32'(out_valid2), 32'h1);
    chk("wrap_pc",   4, out_pc2,         32'h0);
    chk("wrap_instr",4, out_instr2,      32'h0);
    chk("wrap_addr", 4, imem_addr2,      32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
